// File: rtl/riscv_mem.sv
// riscv_mem -- memory-access stage of the riscv pipeline.
//
// ALU results are forwarded to writeback one cycle after they are accepted.
// Loads and stores run one transaction on the data memory using a req/ready
// handshake, followed by an rvalid response for loads. Loaded data is aligned
// and sign- or zero-extended before writeback. Misaligned accesses and
// illegal-size accesses raise a one-cycle fault pulse instead of touching
// memory.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, rdi, result         execute-stage op, destination, ALU result / byte address
//   memfetch, memstore, funct3    load/store qualifiers and access size/sign
//   store_data                    rs2 value for stores
//   stall                         stage busy, upstream holds its inputs
//   dmem_req/we/addr/be/wdata     data-memory request
//   dmem_ready, dmem_rvalid,
//   dmem_rdata                    data-memory accept, read valid, read word
//   wb_valid, wb_rd, wb_data      writeback strobe, register and value
//   fault                         misaligned or illegal-size access pulse
//
// state | meaning
// IDLE  | accepting a new op from execute
// REQ   | memory request outstanding, waiting for dmem_ready
// WAIT  | load accepted by memory, waiting for dmem_rvalid
module riscv_mem #(
    parameter  int XLEN = 32,
    parameter  int REGN = 32,
    localparam int REGA = $clog2(REGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [REGA-1:0] rdi,
    input  logic [XLEN-1:0] result,
    input  logic            memfetch,
    input  logic            memstore,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [REGA-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [REGA-1:0] rd_q;
    logic [2:0]      f3_q;
    logic            we_q;
    logic [3:0]      be_q;

    logic            is_mem;
    logic            is_store;
    logic            bad;
    logic [1:0]      a;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic            accept;
    logic            alu_done;
    logic            fault_now;
    logic            load_done;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_data;

    assign a        = result[1:0];
    assign is_mem   = memfetch | memstore;
    // Both qualifiers set is treated as a load.
    assign is_store = memstore & ~memfetch;

    always_comb begin
        bad = 1'b0;
        case (funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = is_store;
            3'b101:  bad = is_store | a[0];
            default: bad = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so memory only needs the enables.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = store_data;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << a;
                    wdata_c = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << a;
                    wdata_c = {2{store_data[15:0]}};
                end
                default: be_c = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        alu_done  = 1'b0;
        fault_now = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        alu_done = 1'b1;
                    end else if (bad) begin
                        fault_now = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) state_nxt = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    load_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lane = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = lane;
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            fault    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= fault_now;
            if (accept) begin
                addr_q  <= result;
                wdata_q <= wdata_c;
                rd_q    <= rdi;
                f3_q    <= funct3;
                we_q    <= is_store;
                be_q    <= be_c;
            end
            if (alu_done) begin
                wb_valid <= (rdi != '0);
                wb_rd    <= rdi;
                wb_data  <= result;
            end else if (load_done) begin
                wb_valid <= (rd_q != '0);
                wb_rd    <= rd_q;
                wb_data  <= ld_data;
            end
        end
    end

    assign stall      = (state != IDLE);
    assign dmem_req   = (state == REQ);
    assign dmem_we    = we_q & (state == REQ);
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_riscv_mem.sv
// tb_riscv_mem -- self-checking bench for riscv_mem.
// Each op's expected per-cycle outputs are derived from the transaction rules
// (latency, alignment, extension) and stored in per-cycle tables that a
// single compare process checks on every falling edge.
module tb_riscv_mem;

    localparam int NCYC = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  rdi = '0;
    logic [31:0] result = '0;
    logic        memfetch = 1'b0;
    logic        memstore = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    riscv_mem #(.XLEN(32), .REGN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rdi(rdi), .result(result),
        .memfetch(memfetch), .memstore(memstore), .funct3(funct3),
        .store_data(store_data), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit        exp_wb    [NCYC];
    bit [31:0] exp_rd    [NCYC];
    bit [31:0] exp_data  [NCYC];
    bit        exp_fault [NCYC];
    bit        exp_stall [NCYC];
    bit        exp_req   [NCYC];
    bit        exp_we    [NCYC];
    bit [31:0] exp_be    [NCYC];
    bit [31:0] exp_addr  [NCYC];
    bit [31:0] exp_wdata [NCYC];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    function automatic bit legal(input bit ld, input bit [2:0] f3, input bit [1:0] a);
        int nb;
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
        if (!ld && f3 >= 3'd4) return 1'b0;
        nb = 1 << f3[1:0];
        return (int'(a) % nb) == 0;
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [1:0] a, input bit [31:0] w);
        longint v;
        int nb;
        nb = 1 << f3[1:0];
        if (nb == 4) return w;
        v = longint'(w >> (8 * int'(a))) % (longint'(1) << (8 * nb));
        if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC) begin
            chk("wb_valid", cyc, 32'(wb_valid), 32'(exp_wb[cyc]));
            if (exp_wb[cyc]) begin
                chk("wb_rd", cyc, 32'(wb_rd), exp_rd[cyc]);
                chk("wb_data", cyc, wb_data, exp_data[cyc]);
            end
            chk("fault", cyc, 32'(fault), 32'(exp_fault[cyc]));
            chk("stall", cyc, 32'(stall), 32'(exp_stall[cyc]));
            chk("dmem_req", cyc, 32'(dmem_req), 32'(exp_req[cyc]));
            if (exp_req[cyc]) begin
                chk("dmem_addr", cyc, dmem_addr, exp_addr[cyc]);
                chk("dmem_be", cyc, 32'(dmem_be), exp_be[cyc]);
                chk("dmem_we", cyc, 32'(dmem_we), 32'(exp_we[cyc]));
                if (exp_we[cyc]) chk("dmem_wdata", cyc, dmem_wdata, exp_wdata[cyc]);
            end
        end
    end

    // Inputs that the DUT must ignore outside IDLE / WAIT get random values.
    task automatic jitter();
        in_valid    = 1'($urandom_range(0, 1));
        rdi         = 5'($urandom);
        result      = $urandom;
        memfetch    = 1'($urandom_range(0, 1));
        memstore    = 1'($urandom_range(0, 1));
        funct3      = 3'($urandom);
        store_data  = $urandom;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
    endtask

    task automatic quiet();
        in_valid    = 1'b0;
        dmem_ready  = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
    endtask

    task automatic issue(input bit mf, input bit ms, input bit [2:0] f3, input bit [4:0] rd,
                         input bit [31:0] res, input bit [31:0] sd, input bit [31:0] rdata,
                         input int rdy, input int rv, input bit lit, input bit [31:0] litv);
        int c, w, nb;
        bit st;
        bit [1:0] a;
        bit [31:0] be, wd;
        c = cyc;
        a = res[1:0];
        in_valid = 1'b1; memfetch = mf; memstore = ms; funct3 = f3;
        rdi = rd; result = res; store_data = sd;
        dmem_ready  = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        if (!mf && !ms) begin
            if (rd != 0) begin
                exp_wb[c+1] = 1'b1; exp_rd[c+1] = 32'(rd); exp_data[c+1] = res;
            end
            @(negedge clk);
            quiet();
            return;
        end
        st = !mf;
        if (!legal(mf, f3, a)) begin
            exp_fault[c+1] = 1'b1;
            @(negedge clk);
            quiet();
            return;
        end
        nb = 1 << f3[1:0];
        be = st ? 32'(((1 << nb) - 1) << a) : 32'd0;
        wd = (nb == 1) ? sd[7:0] * 32'h01010101 : (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
        for (int i = 0; i <= rdy; i++) begin
            exp_stall[c+1+i] = 1'b1; exp_req[c+1+i] = 1'b1; exp_addr[c+1+i] = res;
            exp_be[c+1+i] = be; exp_we[c+1+i] = st; exp_wdata[c+1+i] = wd;
        end
        w = c + 2 + rdy;
        if (!st) begin
            for (int j = 0; j <= rv; j++) exp_stall[w+j] = 1'b1;
            if (rd != 0) begin
                exp_wb[w+rv+1]   = 1'b1;
                exp_rd[w+rv+1]   = 32'(rd);
                exp_data[w+rv+1] = lit ? litv : model_load(f3, a, rdata);
            end
        end
        @(negedge clk);
        for (int i = 0; i <= rdy; i++) begin
            jitter();
            dmem_ready = (i == rdy);
            @(negedge clk);
        end
        if (st) begin
            quiet();
            return;
        end
        for (int j = 0; j <= rv; j++) begin
            jitter();
            dmem_ready  = 1'($urandom_range(0, 1));
            dmem_rvalid = (j == rv);
            if (j == rv) dmem_rdata = rdata;
            @(negedge clk);
        end
        quiet();
    endtask

    // Word load that is reset while waiting for rvalid; a late rvalid follows.
    task automatic load_reset(input bit [4:0] rd, input bit [31:0] res, input int k);
        int c;
        c = cyc;
        in_valid = 1'b1; memfetch = 1'b1; memstore = 1'b0; funct3 = 3'b010;
        rdi = rd; result = res;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        exp_stall[c+1] = 1'b1; exp_req[c+1] = 1'b1; exp_addr[c+1] = res;
        exp_be[c+1] = 32'd0; exp_we[c+1] = 1'b0;
        for (int j = 0; j <= k; j++) exp_stall[c+2+j] = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        repeat (k) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        repeat (2) @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset wb_rd", cyc, 32'(wb_rd), 32'd0);
        chk("reset wb_data", cyc, wb_data, 32'd0);
        chk("reset dmem_addr", cyc, dmem_addr, 32'd0);
        chk("reset dmem_be", cyc, 32'(dmem_be), 32'd0);
        chk("reset dmem_wdata", cyc, dmem_wdata, 32'd0);
        chk("reset dmem_we", cyc, 32'(dmem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 0, 3'b000, 5'd5, 32'h1234, 0, 0, 0, 0, 1'b0, 0);
        issue(0, 0, 3'b000, 5'd0, 32'h5678, 0, 0, 0, 0, 1'b0, 0);
        @(negedge clk);

        issue(1, 0, 3'b000, 5'd3, 32'h103, 0, 32'h80AABBCC, 0, 0, 1'b1, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 5'd4, 32'h103, 0, 32'h80AABBCC, 0, 0, 1'b1, 32'h00000080);
        issue(1, 0, 3'b101, 5'd6, 32'h102, 0, 32'h80AABBCC, 1, 2, 1'b1, 32'h000080AA);

        issue(0, 1, 3'b001, 5'd8, 32'h102, 32'hDEADBEEF, 0, 3, 0, 1'b0, 0);

        issue(1, 0, 3'b010, 5'd9, 32'h101, 0, 0, 0, 0, 1'b0, 0);
        issue(0, 1, 3'b100, 5'd10, 32'h200, 32'hAA, 0, 0, 0, 1'b0, 0);
        @(negedge clk);

        load_reset(5'd11, 32'h300, 3);
        @(negedge clk);

        issue(1, 0, 3'b010, 5'd7, 32'h400, 0, 32'hCAFEF00D, 0, 0, 1'b1, 32'hCAFEF00D);
        issue(1, 0, 3'b010, 5'd9, 32'h404, 0, 32'h0BADBEEF, 0, 0, 1'b1, 32'h0BADBEEF);

        for (int n = 0; n < 400 && cyc < NCYC - 64; n++) begin
            int kind;
            bit mf, ms;
            bit [4:0] rd;
            kind = $urandom_range(0, 2);
            mf = (kind == 1);
            ms = (kind == 2) || (kind == 1 && $urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            issue(mf, ms, 3'($urandom), rd, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mem.md
# riscv_mem

Memory-access stage of the riscv pipeline, sitting directly downstream of the execute stage. It consumes the execute stage's ALU result, destination register and load/store qualifiers. It either forwards ALU results to writeback, or runs a load/store transaction against the data memory over a req/ready + rvalid handshake. Loaded data is aligned and sign- or zero-extended before writeback.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported (byte lanes = XLEN/8 = 4)
- REGN, 32, register count; REGA = $clog2(REGN) is a derived localparam

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  execute-stage output valid this cycle
- rdi  input  REGA  destination register from execute
- result  input  XLEN  ALU result, or byte effective address for loads/stores
- memfetch  input  1  op is a load
- memstore  input  1  op is a store
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- store_data  input  XLEN  rs2 value for stores
- stall  output  1  stage busy; upstream must hold its inputs
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = write
- dmem_addr  output  XLEN  byte address
- dmem_be  output  4  byte enables
- dmem_wdata  output  XLEN  lane-replicated write data
- dmem_ready  input  1  memory accepts request
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  XLEN  read word (aligned word containing the address)
- wb_valid  output  1  writeback strobe, one-cycle pulse
- wb_rd  output  REGA  writeback register
- wb_data  output  XLEN  writeback value
- fault  output  1  one-cycle pulse on misaligned or illegal-size access

## Operation
- FSM states: IDLE, REQ, WAIT. stall = (state != IDLE), combinational from state.
- Inputs are sampled only in IDLE with in_valid=1.
- Non-memory op (memfetch=0, memstore=0):
  - next cycle wb_valid=1, wb_rd=rdi, wb_data=result
  - wb_valid is suppressed when rdi=0
  - state stays IDLE
- Memory op: if memfetch and memstore are both 1, treat the op as a load.
- Fault checks, with a = result[1:0]:
  - H/HU with a[0]=1 → fault
  - W with a≠0 → fault
  - funct3 ∈ {011, 110, 111} → fault
  - stores only allow B/H/W; funct3 100 or 101 with memstore → fault
  - on fault: fault pulses next cycle, no request is issued, no writeback, state stays IDLE.
- Legal memory op: latch address, rd, funct3, we and the lane data; go to REQ.
- REQ: dmem_req=1. addr, we, be and wdata are held stable until dmem_ready=1. On the handshake:
  - store → IDLE, no writeback
  - load → WAIT
- WAIT: dmem_rvalid is sampled only in this state.
  - on rvalid: lane = dmem_rdata >> (8·a)
  - B: sign-extend lane[7:0]; BU: zero-extend lane[7:0]
  - H: sign-extend lane[15:0]; HU: zero-extend lane[15:0]
  - W: full word
  - pulse wb_valid (unless rd=0) with wb_rd = latched rd; go to IDLE.
- Byte enables and write data:
  - B: be = 0001 << a, wdata = {4{store_data[7:0]}}
  - H: be = 0011 << a, wdata = {2{store_data[15:0]}}
  - W: be = 1111, wdata = store_data
  - be is 0000 and dmem_we=0 for loads.

## Timing
- Reset values: all outputs 0, state IDLE, latched fields 0.
- rst asserted mid-transaction: the FSM returns to IDLE the next edge. dmem_req drops and no wb_valid/fault is produced for the aborted op. A late dmem_rvalid after reset is ignored.
- ALU pass-through latency: 1 cycle (in_valid at edge N → wb_valid high in cycle N+1).
- Load, best case (ready=1 in the first REQ cycle, rvalid in the first WAIT cycle):
  - in_valid cycle 0, REQ cycle 1, WAIT cycle 2, wb_valid cycle 3
  - stall is high in cycles 1–2
- Store, best case: REQ cycle 1, IDLE cycle 2; stall is high in cycle 1 only.
- A new op can be accepted in the first IDLE cycle after completion: back-to-back with no bubble beyond the stall window.
- dmem_rvalid asserted in the same cycle as the request handshake is not sampled.
- wb_valid and fault are registered, single-cycle pulses.

## Test plan
- Reset, then ALU op: rdi=5, result=0x1234 → wb_valid=1, wb_rd=5, wb_data=0x1234 next cycle. Repeat with rdi=0 → wb_valid stays 0.
- LB at address 0x103, dmem_rdata=0x80AABBCC → wb_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080AA.
- SH at 0x102 with store_data=0xDEADBEEF, dmem_ready held 0 for 3 cycles:
  - dmem_req/addr/be=1100/wdata=0xBEEFBEEF stay stable for all 3 cycles
  - stall=1 throughout
  - completion one cycle after ready, no wb_valid
- LW at 0x101 → fault pulse, dmem_req never asserted. SB with funct3=100 → fault.
- Load with rvalid delayed 4 cycles, and rst asserted while in WAIT → IDLE, dmem_req=0, a subsequent rvalid produces no wb_valid.
- Two back-to-back loads, ready and rvalid immediate → two wb_valid pulses 3 cycles apart with correct wb_rd for each.
